// File: rtl/game_pkg.sv
// Shared types, widths and tuning constants for the game-flow sequencer.
package game_pkg;

    localparam int unsigned BASE_PERIOD  = 6;
    localparam int unsigned MIN_PERIOD   = 2;
    localparam int unsigned LEVEL_SCORE  = 10;
    localparam int unsigned MAX_LEVEL    = 3;
    localparam int unsigned CRASH_FRAMES = 60;
    localparam int unsigned FLASH_FRAMES = 8;

    localparam int unsigned SCORE_W     = 8;
    localparam int unsigned LEVEL_W     = 2;
    localparam int unsigned THRESH_W    = SCORE_W + 1;
    localparam int unsigned PERIOD_W    = $clog2(BASE_PERIOD + 1);
    localparam int unsigned CRASH_CNT_W = $clog2(CRASH_FRAMES);
    localparam int unsigned FLASH_CNT_W = $clog2(FLASH_FRAMES);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StCrash = 2'd2,
        StOver  = 2'd3
    } state_e;

    // Frames per step shrink with level but never drop below the floor.
    function automatic logic [PERIOD_W-1:0] period_for(input logic [LEVEL_W-1:0] level);
        if (32'(level) + MIN_PERIOD >= BASE_PERIOD) return PERIOD_W'(MIN_PERIOD);
        return PERIOD_W'(BASE_PERIOD - 32'(level));
    endfunction

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the sequencer and the rest of the game.
interface game_sequencer_if import game_pkg::*; ();

    logic               start;
    logic               frame_start;
    logic               crash;
    logic [SCORE_W-1:0] score;
    state_e             state;
    logic               step_en;
    logic               clear;
    logic               game_over;
    logic               flash;
    logic [LEVEL_W-1:0] level;

    modport master (
        output start, frame_start, crash, score,
        input  state, step_en, clear, game_over, flash, level
    );

    modport slave (
        input  start, frame_start, crash, score,
        output state, step_en, clear, game_over, flash, level
    );

endinterface

// File: rtl/frame_step_timer.sv
// Counts frame pulses while enabled and emits a registered step pulse every `period` frames.
module frame_step_timer import game_pkg::*; (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                restart,
    input  logic                frame_start,
    input  logic [PERIOD_W-1:0] period,
    output logic                step_en
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                step_q, step_d;

    always_comb begin
        cnt_d  = cnt_q;
        step_d = 1'b0;
        if (restart) begin
            cnt_d = '0;
        end else if (enable && frame_start) begin
            // >= guards against a period shrinking below the current count
            if (cnt_q >= period - PERIOD_W'(1)) begin
                cnt_d  = '0;
                step_d = 1'b1;
            end else begin
                cnt_d = cnt_q + PERIOD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
        end
    end

    assign step_en = step_q;

endmodule

// File: rtl/game_sequencer.sv
// Game-flow FSM (IDLE/PLAY/CRASH/OVER) with frame-locked object stepping,
// difficulty levels and the crash flash sequence.
module game_sequencer import game_pkg::*; (
    input logic             clk,
    input logic             reset,
    game_sequencer_if.slave bus
);

    state_e                 state_q, state_d;
    logic                   start_q;
    logic                   start_rise;
    logic                   go_play, go_crash, go_over;
    logic                   step_en;
    logic                   clear_q;
    logic [LEVEL_W-1:0]     level_q;
    logic [THRESH_W-1:0]    thresh_q;
    logic [CRASH_CNT_W-1:0] crash_cnt_q;
    logic [FLASH_CNT_W-1:0] flash_cnt_q;
    logic                   flash_q;

    assign start_rise = bus.start & ~start_q;

    always_comb begin
        state_d  = state_q;
        go_play  = 1'b0;
        go_crash = 1'b0;
        go_over  = 1'b0;
        unique case (state_q)
            StIdle, StOver: begin
                if (start_rise) begin
                    state_d = StPlay;
                    go_play = 1'b1;
                end
            end
            StPlay: begin
                if (bus.crash) begin
                    state_d  = StCrash;
                    go_crash = 1'b1;
                end
            end
            StCrash: begin
                if (bus.frame_start && crash_cnt_q == CRASH_CNT_W'(CRASH_FRAMES - 1)) begin
                    state_d = StOver;
                    go_over = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= bus.start;
        end
    end

    // A crash in the same cycle as a due frame suppresses that step.
    frame_step_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .enable      (state_q == StPlay && !bus.crash),
        .restart     (go_play | go_crash),
        .frame_start (bus.frame_start),
        .period      (period_for(level_q)),
        .step_en     (step_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clear_q  <= 1'b0;
            level_q  <= '0;
            thresh_q <= THRESH_W'(LEVEL_SCORE);
        end else begin
            clear_q <= go_play;
            if (go_play) begin
                level_q  <= '0;
                thresh_q <= THRESH_W'(LEVEL_SCORE);
            end else if (step_en && {1'b0, bus.score} >= thresh_q &&
                         level_q < LEVEL_W'(MAX_LEVEL)) begin
                level_q  <= level_q + LEVEL_W'(1);
                thresh_q <= thresh_q + THRESH_W'(LEVEL_SCORE);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crash_cnt_q <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else if (go_crash) begin
            crash_cnt_q <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b1;
        end else if (state_q == StCrash && bus.frame_start) begin
            if (go_over) begin
                crash_cnt_q <= '0;
                flash_cnt_q <= '0;
                flash_q     <= 1'b0;
            end else begin
                crash_cnt_q <= crash_cnt_q + CRASH_CNT_W'(1);
                if (flash_cnt_q == FLASH_CNT_W'(FLASH_FRAMES - 1)) begin
                    flash_cnt_q <= '0;
                    flash_q     <= ~flash_q;
                end else begin
                    flash_cnt_q <= flash_cnt_q + FLASH_CNT_W'(1);
                end
            end
        end
    end

    assign bus.state     = state_q;
    assign bus.step_en   = step_en;
    assign bus.clear     = clear_q;
    assign bus.game_over = (state_q == StCrash) || (state_q == StOver);
    assign bus.flash     = flash_q;
    assign bus.level     = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed self-checking bench for game_sequencer.
module tb_game_sequencer;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    game_sequencer_if bus ();

    game_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Frame pulse high for exactly one rising edge; returns on the following falling edge.
    task automatic pulse_frame();
        bus.frame_start = 1'b1;
        @(negedge clk);
        bus.frame_start = 1'b0;
    endtask

    task automatic run_step(input int period, input int exp_level, input string name);
        for (int i = 1; i <= period; i++) begin
            pulse_frame();
            total++;
            if (bus.step_en !== (i == period)) begin
                bad++;
                $display("FAIL %s step_en after frame %0d: got %b want %b", name, i, bus.step_en,
                         (i == period));
            end
        end
        @(negedge clk);
        total++;
        if (bus.step_en !== 1'b0) begin
            bad++;
            $display("FAIL %s step_en width: got %b want 0", name, bus.step_en);
        end
        total++;
        if (bus.level !== 2'(exp_level)) begin
            bad++;
            $display("FAIL %s level: got %0d want %0d", name, bus.level, exp_level);
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({bus.state, bus.step_en, bus.clear, bus.game_over, bus.flash, bus.level} !== 8'd0) begin
            bad++;
            $display("FAIL reset outputs: got state=%0d step=%b clr=%b go=%b fl=%b lvl=%0d want all 0",
                     bus.state, bus.step_en, bus.clear, bus.game_over, bus.flash, bus.level);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_start_and_step();
        // frame pulses in IDLE must not produce steps
        pulse_frame();
        total++;
        if (bus.step_en !== 1'b0 || bus.state !== StIdle) begin
            bad++;
            $display("FAIL idle_ignore: got state=%0d step=%b want 0/0", bus.state, bus.step_en);
        end
        bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.state !== StPlay || bus.clear !== 1'b1) begin
            bad++;
            $display("FAIL start_enter: got state=%0d clear=%b want 1/1", bus.state, bus.clear);
        end
        @(negedge clk);
        total++;
        if (bus.clear !== 1'b0) begin
            bad++;
            $display("FAIL clear_width: got %b want 0", bus.clear);
        end
        run_step(6, 0, "first_step");
        bus.start = 1'b0;
    endtask

    task automatic test_level_ramp();
        bus.score = 8'd10;
        run_step(6, 1, "lvl1");
        bus.score = 8'd20;
        run_step(5, 2, "lvl2");
        bus.score = 8'd30;
        run_step(4, 3, "lvl3");
        bus.score = 8'd35;
        run_step(3, 3, "lvl_cap35");
        bus.score = 8'd40;
        run_step(3, 3, "lvl_cap40");
    endtask

    task automatic test_crash_sequence();
        pulse_frame();
        pulse_frame();
        // third frame would be due (period 3) but crash arrives with it
        bus.crash = 1'b1;
        pulse_frame();
        bus.crash = 1'b0;
        total++;
        if (bus.step_en !== 1'b0 || bus.state !== StCrash || bus.game_over !== 1'b1 ||
            bus.flash !== 1'b1) begin
            bad++;
            $display("FAIL crash_entry: got step=%b state=%0d go=%b fl=%b want 0/2/1/1",
                     bus.step_en, bus.state, bus.game_over, bus.flash);
        end
        for (int f = 1; f <= CRASH_FRAMES; f++) begin
            pulse_frame();
            if (f == 7 || f == 8 || f == 15 || f == 16) begin
                total++;
                if (bus.flash !== ((f == 7 || f == 16) ? 1'b1 : 1'b0)) begin
                    bad++;
                    $display("FAIL flash after frame %0d: got %b want %b", f, bus.flash,
                             (f == 7 || f == 16));
                end
            end
            if (f == 10) begin
                bus.start = 1'b1;
                @(negedge clk);
                @(negedge clk);
                bus.start = 1'b0;
                total++;
                if (bus.state !== StCrash || bus.clear !== 1'b0) begin
                    bad++;
                    $display("FAIL crash_start_ignored: got state=%0d clear=%b want 2/0",
                             bus.state, bus.clear);
                end
            end
            if (f == 59) begin
                total++;
                if (bus.state !== StCrash) begin
                    bad++;
                    $display("FAIL crash_frame59: got state=%0d want 2", bus.state);
                end
            end
            if (bus.step_en !== 1'b0) begin
                total++;
                bad++;
                $display("FAIL crash_step frame %0d: got 1 want 0", f);
            end
        end
        total++;
        if (bus.state !== StOver || bus.flash !== 1'b0 || bus.game_over !== 1'b1) begin
            bad++;
            $display("FAIL over_entry: got state=%0d fl=%b go=%b want 3/0/1", bus.state, bus.flash,
                     bus.game_over);
        end
    endtask

    task automatic test_over_hold();
        int clears = 0;
        int enters = 0;
        bus.score = 8'd0;
        bus.start = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (bus.clear === 1'b1) clears++;
            if (bus.state === StPlay && c == 0) enters++;
        end
        bus.start = 1'b0;
        total++;
        if (clears != 1 || enters != 1 || bus.state !== StPlay) begin
            bad++;
            $display("FAIL over_hold: got clears=%0d enters=%0d state=%0d want 1/1/1", clears,
                     enters, bus.state);
        end
        total++;
        if (bus.level !== 2'd0 || bus.game_over !== 1'b0) begin
            bad++;
            $display("FAIL restart_level: got lvl=%0d go=%b want 0/0", bus.level, bus.game_over);
        end
        run_step(6, 0, "restart_period");
    endtask

    task automatic test_reset_mid_crash();
        bus.crash = 1'b1;
        @(negedge clk);
        bus.crash = 1'b0;
        total++;
        if (bus.state !== StCrash || bus.flash !== 1'b1) begin
            bad++;
            $display("FAIL mid_crash_entry: got state=%0d fl=%b want 2/1", bus.state, bus.flash);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if ({bus.state, bus.step_en, bus.clear, bus.game_over, bus.flash, bus.level} !== 8'd0) begin
            bad++;
            $display("FAIL async_reset: got state=%0d step=%b clr=%b go=%b fl=%b lvl=%0d want all 0",
                     bus.state, bus.step_en, bus.clear, bus.game_over, bus.flash, bus.level);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (bus.clear !== 1'b0 || bus.state !== StIdle) begin
            bad++;
            $display("FAIL reset_no_clear: got clr=%b state=%0d want 0/0", bus.clear, bus.state);
        end
        bus.start = 1'b1;
        @(negedge clk);
        total++;
        if (bus.state !== StPlay || bus.clear !== 1'b1 || bus.level !== 2'd0) begin
            bad++;
            $display("FAIL post_reset_start: got state=%0d clr=%b lvl=%0d want 1/1/0", bus.state,
                     bus.clear, bus.level);
        end
        bus.start = 1'b0;
        @(negedge clk);
        run_step(6, 0, "post_reset_step");
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.frame_start = 1'b0;
        bus.crash       = 1'b0;
        bus.score       = 8'd0;
        @(negedge clk);
        test_reset();
        test_start_and_step();
        test_level_ramp();
        test_crash_sequence();
        test_over_hold();
        test_reset_mid_crash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
